// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM initiator: default geometry,
// FSM encoding and request-type bit values.
package spram_pkg;

  localparam int SPRAM_ADDR_W = 4;
  localparam int SPRAM_DATA_W = 8;
  localparam int SPRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  // RD lasts lat+1 cycles: the down-counter runs lat..0; clamp to the 3-bit range.
  function automatic logic [2:0] rd_cnt_load(input int lat);
    if (lat < 1)
      return 3'd1;
    else if (lat > 7)
      return 3'd7;
    else
      return 3'(lat);
  endfunction

endpackage

// File: rtl/spram_bus_io.sv
// Data-bus pad logic: tristate driver onto the shared RAM bus and the
// load-enabled capture register for read data.
module spram_bus_io
  import spram_pkg::*;
#(
  parameter int DATA_W = SPRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cap_en,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] mem_data
);

  assign mem_data = oe ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (cap_en)
      rdata <= mem_data;
  end

endmodule

// File: rtl/spram_master.sv
// Initiator for the single-port RAM: valid/ready request intake, write/read
// strobe sequencing with a mandatory idle turnaround, and one-cycle read responses.
module spram_master
  import spram_pkg::*;
#(
  parameter int ADDR_W = SPRAM_ADDR_W,
  parameter int DATA_W = SPRAM_DATA_W,
  parameter int RD_LAT = SPRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_we,
  output logic              mem_re,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam logic [2:0] RD_CNT_INIT = rd_cnt_load(RD_LAT);

  state_t            state;
  logic [2:0]        rd_cnt;
  logic              oe;
  logic              accept;
  logic              cap_en;
  logic [DATA_W-1:0] wdata_q;

  assign accept = req_valid && req_ready;
  assign cap_en = (state == ST_RD) && (rd_cnt == 3'd0);

  // Write data is a plain datapath register; the strobes guard its use.
  always_ff @(posedge clk) begin
    if (accept && (req_write == REQ_WR))
      wdata_q <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rd_cnt      <= 3'd0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      oe          <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_write == REQ_WR) begin
              state       <= ST_WR;
              mem_we      <= 1'b1;
              oe          <= 1'b1;
              mem_wr_addr <= req_addr;
            end else begin
              state       <= ST_RD;
              mem_re      <= 1'b1;
              mem_rd_addr <= req_addr;
              rd_cnt      <= RD_CNT_INIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_WR: begin
          state     <= ST_IDLE;
          mem_we    <= 1'b0;
          oe        <= 1'b0;
          req_ready <= 1'b1;
        end
        ST_RD: begin
          // The capture register loads on this same edge when the count expires.
          if (rd_cnt == 3'd0) begin
            state     <= ST_IDLE;
            mem_re    <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt - 3'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          oe        <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

  spram_bus_io #(
    .DATA_W (DATA_W)
  ) u_bus_io (
    .clk      (clk),
    .rst      (rst),
    .oe       (oe),
    .wdata    (wdata_q),
    .cap_en   (cap_en),
    .rdata    (rsp_rdata),
    .mem_data (mem_data)
  );

endmodule

// File: tb/tb_spram_master.sv
// Bench for spram_master: two instances (RAM latency 1 and 3) each wired to a
// behavioural single-port RAM, checked against a reference memory and response queue.
module tb_spram_master;
  import spram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid [2];
  logic       req_write [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic [3:0] wa        [2];
  logic [3:0] ra        [2];
  logic       we        [2];
  logic       re        [2];
  wire  [7:0] bus0;
  wire  [7:0] bus1;

  spram_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .mem_wr_addr(wa[0]),
    .mem_rd_addr(ra[0]), .mem_we(we[0]), .mem_re(re[0]), .mem_data(bus0));

  spram_master #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .mem_wr_addr(wa[1]),
    .mem_rd_addr(ra[1]), .mem_we(we[1]), .mem_re(re[1]), .mem_data(bus1));

  // RAM models: data appears LAT edges after the first edge that samples re=1.
  logic [7:0] ram  [2][16];
  logic       sr_v [2][3];
  logic [3:0] sr_a [2][3];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i]) ram[i][wa[i]] <= (i == 0) ? bus0 : bus1;
      sr_v[i][0] <= re[i];
      sr_a[i][0] <= ra[i];
      for (int k = 1; k < 3; k++) begin
        sr_v[i][k] <= sr_v[i][k-1];
        sr_a[i][k] <= sr_a[i][k-1];
      end
    end
  end

  assign bus0 = (sr_v[0][0] && re[0] && !we[0]) ? ram[0][sr_a[0][0]] : 8'bz;
  assign bus1 = (sr_v[1][2] && re[1] && !we[1]) ? ram[1][sr_a[1][2]] : 8'bz;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] ref_mem   [2][16];
  logic [7:0] exp_wbus  [2];
  logic [3:0] exp_waddr [2];
  logic [3:0] exp_raddr [2];
  logic       prev_we   [2];
  logic       prev_re   [2];
  logic       prev_rsp  [2];
  int         rsp_cnt   [2];

  typedef struct {
    logic       w;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vec [32];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  task automatic monitor();
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        b = (i == 0) ? bus0 : bus1;
        chk("we_re_exclusive", 32'(we[i] & re[i]), 32'd0);
        chk("ready_only_in_idle", 32'(req_ready[i] & (we[i] | re[i])), 32'd0);
        if (re[i]) begin
          chk("wr_to_rd_turnaround", 32'(prev_we[i]), 32'd0);
          chk("rd_addr", 32'(ra[i]), 32'(exp_raddr[i]));
        end
        if (we[i]) begin
          chk("rd_to_wr_turnaround", 32'(prev_re[i]), 32'd0);
          chk("wr_addr", 32'(wa[i]), 32'(exp_waddr[i]));
          chk("wr_bus_data", 32'(b), 32'(exp_wbus[i]));
        end
        if (rsp_valid[i]) begin
          rsp_cnt[i]++;
          chk("rsp_pulse_width", 32'(prev_rsp[i]), 32'd0);
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            if (i == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata[i]), 32'(e));
          end
        end
        prev_we[i]  = we[i];
        prev_re[i]  = re[i];
        prev_rsp[i] = rsp_valid[i];
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the acceptance edge.
  task automatic send(input int i, input logic w, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] e, input bit keep);
    int n;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("req_accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    if (w == REQ_WR) begin
      exp_wbus[i]     = d;
      exp_waddr[i]    = a;
      ref_mem[i][a]   = d;
    end else begin
      exp_raddr[i] = a;
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic read_lat(input int i, input logic [3:0] a, input logic [7:0] e, input int lat);
    int n;
    send(i, REQ_RD, a, 8'h00, e, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[i] && n < 20);
    chk("rd_latency", 32'(n), 32'(lat));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    chk("rst_mem_we", 32'(we[i]), 32'd0);
    chk("rst_mem_re", 32'(re[i]), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata[i]), 32'd0);
    chk("rst_wr_addr", 32'(wa[i]), 32'd0);
    chk("rst_rd_addr", 32'(ra[i]), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_queue_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  task automatic run_tests();
    int base;
    int gap;
    logic       w;
    logic [3:0] a;
    logic [7:0] d;

    // Reset state and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(req_ready[0]), 32'd1);

    // Single write then read with latency
    send(0, REQ_WR, 4'd5, 8'h0F, 8'h00, 1'b0);
    read_lat(0, 4'd5, 8'h0F, 3);

    // Table: ascending writes, descending reads
    for (int i = 0; i < 16; i++)
      vec[i] = '{1'b1, 4'(i), 8'(i * 16), 8'h00};
    for (int i = 0; i < 16; i++)
      vec[16 + i] = '{1'b0, 4'(15 - i), 8'h00, 8'((15 - i) * 16)};
    base = rsp_cnt[0];
    for (int i = 0; i < 32; i++)
      send(0, vec[i].w, vec[i].addr, vec[i].wdata, vec[i].exp_rdata, 1'b0);
    drain();
    chk("table_rsp_count", 32'(rsp_cnt[0] - base), 32'd16);

    // Back-to-back direction changes with req_valid held high
    send(0, REQ_WR, 4'd2, 8'h11, 8'h00, 1'b1);
    send(0, REQ_RD, 4'd2, 8'h00, 8'h11, 1'b1);
    send(0, REQ_WR, 4'd9, 8'h99, 8'h00, 1'b1);
    send(0, REQ_RD, 4'd9, 8'h00, 8'h99, 1'b0);
    drain();

    // Request fields change after acceptance
    send(0, REQ_WR, 4'd7, 8'h55, 8'h00, 1'b0);
    req_addr[0]  = 4'd3;
    req_wdata[0] = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("ram_addr7", 32'(ram[0][7]), 32'h55);
    chk("ram_addr3", 32'(ram[0][3]), 32'(ref_mem[0][3]));

    // Reset during the second RD cycle discards the read
    send(0, REQ_WR, 4'd5, 8'h0F, 8'h00, 1'b0);
    base = rsp_cnt[0];
    req_valid[0] = 1'b1;
    req_write[0] = REQ_RD;
    req_addr[0]  = 4'd5;
    gap = 0;
    while (!req_ready[0] && gap < 50) begin
      @(posedge clk); #1;
      gap++;
    end
    @(posedge clk); #1;
    exp_raddr[0] = 4'd5;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(req_ready[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_rsp_after_reset", 32'(rsp_cnt[0] - base), 32'd0);
    read_lat(0, 4'd5, 8'h0F, 3);

    // Randomized traffic against the reference memory
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      send(0, w, a, d, ref_mem[0][a], 1'b0);
    end
    drain();

    // Three-cycle RAM latency
    send(1, REQ_WR, 4'd4, 8'h3C, 8'h00, 1'b0);
    send(1, REQ_WR, 4'd11, 8'hC3, 8'h00, 1'b0);
    read_lat(1, 4'd4, 8'h3C, 5);
    read_lat(1, 4'd11, 8'hC3, 5);
    d = 8'($urandom);
    send(1, REQ_WR, 4'd0, d, 8'h00, 1'b0);
    read_lat(1, 4'd0, d, 5);
    drain();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 4'd0;
      req_wdata[i] = 8'd0;
      exp_wbus[i]  = 8'd0;
      exp_waddr[i] = 4'd0;
      exp_raddr[i] = 4'd0;
      prev_we[i]   = 1'b0;
      prev_re[i]   = 1'b0;
      prev_rsp[i]  = 1'b0;
      rsp_cnt[i]   = 0;
    end
    fork
      monitor();
      run_tests();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_master.md
# spram_master

Initiator-side controller for the single-port RAM (`singleportram`) in this design. It accepts read/write requests on a valid/ready handshake and drives the RAM's `wr_addr`/`rd_addr`/`we`/`re` strobes. It owns the shared bidirectional data bus, releasing it and sampling it for reads. Read results are returned on a one-cycle response pulse. It replaces hand-driven task sequences with a synthesizable initiator that guarantees bus turnaround.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width.
- `DATA_W`, 8: RAM data width.
- `RD_LAT`, 1: cycles from the first posedge sampling `mem_re`=1 until RAM data is valid on `mem_data`. Legal range is 1–7.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: target address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle pulse; read data valid.
- `rsp_rdata` out DATA_W: read data; holds its last value between pulses.
- `mem_wr_addr` out ADDR_W: RAM write address.
- `mem_rd_addr` out ADDR_W: RAM read address.
- `mem_we` out 1: RAM write enable.
- `mem_re` out 1: RAM read enable.
- `mem_data` inout DATA_W: shared data bus; driven only in the WR state, otherwise high-Z.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WR: one cycle.
  - RD: RD_LAT+1 cycles, counted by a 3-bit down-counter.
- Handshake: a request is accepted on a posedge with `req_valid`&&`req_ready`. Address and data are registered at acceptance; later changes on `req_*` are ignored.
- IDLE→WR on an accepted write. In WR:
  - `mem_we`=1, `mem_re`=0.
  - `mem_wr_addr` = registered address.
  - `mem_data` = registered data.
  - Then WR→IDLE.
- IDLE→RD on an accepted read. In RD:
  - `mem_re`=1, `mem_we`=0.
  - `mem_rd_addr` = registered address.
  - `mem_data` = high-Z.
  - On the posedge that ends the last RD cycle, `mem_data` is captured into `rsp_rdata`. Then RD→IDLE.
- `rsp_valid`=1 for exactly the first IDLE cycle after RD.
- `mem_we` and `mem_re` are never both 1.
- `mem_data` is driven only while `mem_we`=1.
- Every access returns through IDLE, where `mem_we`=`mem_re`=0 and the bus is released. This gives at least one turnaround cycle on every write→read and read→write transition.
- `mem_wr_addr` and `mem_rd_addr` hold their last values when not strobed.
- Reset while `rst`=1, including mid-access:
  - State goes to IDLE and the read counter to 0.
  - `req_ready`=0, `rsp_valid`=0, `mem_we`=0, `mem_re`=0, `mem_data` high-Z.
  - `rsp_rdata`=0, `mem_wr_addr`=0, `mem_rd_addr`=0.
  - A pending read is discarded and produces no response.
  - `req_ready` rises on the first cycle after `rst` deasserts.
- Simultaneous `rsp_valid` and a new request acceptance in the same IDLE cycle are legal.

## Timing
- Write occupancy: 2 cycles (accept + WR). Back-to-back writes run at 1 per 2 cycles.
- Read latency from the acceptance edge to `rsp_valid` high is RD_LAT+2 cycles. For example, with RD_LAT=1: accept at edge 0, RD during edges 1–2, capture at edge 2, `rsp_valid` during cycle 3.
- Read occupancy: RD_LAT+2 cycles, including the IDLE response cycle.
- All outputs are registered except the `mem_data` tristate. The tristate enable is a registered `oe` bit equal to (state==WR).

## Structure
- Shared package `spram_pkg`:
  - default `ADDR_W`/`DATA_W`/`RD_LAT` constants;
  - FSM state encoding (IDLE, WR, RD);
  - request type bit constants (`REQ_RD`=0, `REQ_WR`=1).
- Sub-module `spram_bus_io` contains the tristate driver on `mem_data` (driven when `oe`), plus the capture register for read data with load enable. The FSM and handshake stay in `spram_master`.

## Test plan
The bench instantiates `singleportram` with RD_LAT=1, wired to `spram_master`.
- Reset, then request write addr 5 data 0x0F, then read addr 5 → `rsp_valid` one pulse exactly 3 cycles after read acceptance, `rsp_rdata`=0x0F.
- Writes 0x00→addr 0 … 0xF0→addr 15, then reads addr 15 down to 0 → responses 0xF0, 0xE0, … 0x00, in order, one per read.
- Write→read→write→read back-to-back with `req_valid` held high → bus never driven while `mem_re`=1. At least one cycle with `mem_we`=`mem_re`=0 and `mem_data`=Z sits between each direction change; `req_ready`=0 outside IDLE.
- `req_addr`/`req_wdata` changed (to 3/0xAA) during WR after accepting write 7/0x55 → RAM addr 7 holds 0x55, addr 3 unchanged.
- `rst` pulsed in the 2nd RD cycle of a read of addr 5 → no `rsp_valid`, all outputs at reset values during `rst`. `req_ready`=1 the cycle after release, and a subsequent read of addr 5 returns 0x0F.
- Re-run with RD_LAT=3 and a 3-cycle RAM model → read latency of 5 cycles, correct data.
